frame_sample_tx: RTL and testbench

- Source end of the Collect/Valid/Data capture interface consumed by the histogram/frame-capture block.
- Holds one frame of LENGTH samples, loaded by a host write port, and replays it on Start: raises Collect, emits LENGTH single-cycle Valid/Data beats with a programmable inter-beat gap, then drops Collect.
- Enforces a guaranteed Collect-low hold window so the receiver's slower-clock readout and sort can finish before the next frame starts.

---
 rtl/frame_tx_pkg.sv | 19 +
 rtl/frame_sample_tx_if.sv | 29 ++
 rtl/frame_tx_buf.sv | 44 ++++
 rtl/frame_sample_tx.sv | 166 ++++++++++++++++
 tb/tb_frame_sample_tx.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_tx_pkg.sv
// rtl/frame_tx_pkg.sv - shared constants and FSM state type for frame_sample_tx
// Default frame geometry, counter widths and the replay FSM state encoding.
package frame_tx_pkg;

    localparam int DEF_DATA_SIZE   = 4;
    localparam int DEF_LENGTH      = 64;
    localparam int DEF_LENGTH_SIZE = 6;
    localparam int GAP_W           = 4;
    localparam int HOLD_W          = 8;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SEND,
        POST,
        HOLD
    } tx_state_e;

endpackage

// File: rtl/frame_sample_tx_if.sv
// rtl/frame_sample_tx_if.sv - host load port and Collect/Valid/Data capture stream
// master: frame_sample_tx (drives LdErr, Collect, Valid, Data; receives LdEn, LdAdd, LdData)
// slave : host/receiver side (drives LdEn, LdAdd, LdData; receives LdErr, Collect, Valid, Data)
interface frame_sample_tx_if
    import frame_tx_pkg::*;
#(
    parameter int DATA_SIZE   = DEF_DATA_SIZE,
    parameter int LENGTH_SIZE = DEF_LENGTH_SIZE
) ();

    logic                   LdEn;
    logic [LENGTH_SIZE-1:0] LdAdd;
    logic [DATA_SIZE-1:0]   LdData;
    logic                   LdErr;
    logic                   Collect;
    logic                   Valid;
    logic [DATA_SIZE-1:0]   Data;

    modport master (
        input  LdEn, LdAdd, LdData,
        output LdErr, Collect, Valid, Data
    );

    modport slave (
        output LdEn, LdAdd, LdData,
        input  LdErr, Collect, Valid, Data
    );

endinterface

// File: rtl/frame_tx_buf.sv
// rtl/frame_tx_buf.sv - frame buffer, one write port and one registered read port
// wr_en_i/wr_addr_i/wr_data_i : synchronous write
// rd_en_i/rd_addr_i           : read request, data appears on rd_data_o next cycle
// rd_data_o                   : registered read data, holds its value when rd_en_i=0
module frame_tx_buf
    import frame_tx_pkg::*;
#(
    parameter int DATA_SIZE   = DEF_DATA_SIZE,
    parameter int LENGTH      = DEF_LENGTH,
    parameter int LENGTH_SIZE = DEF_LENGTH_SIZE
) (
    input  logic                   clk200,
    input  logic                   rstn,
    input  logic                   wr_en_i,
    input  logic [LENGTH_SIZE-1:0] wr_addr_i,
    input  logic [DATA_SIZE-1:0]   wr_data_i,
    input  logic                   rd_en_i,
    input  logic [LENGTH_SIZE-1:0] rd_addr_i,
    output logic [DATA_SIZE-1:0]   rd_data_o
);

    logic [DATA_SIZE-1:0] mem_q [LENGTH];
    logic [DATA_SIZE-1:0] rd_data_q;

    // Storage carries no reset; its contents are meaningless until loaded.
    always_ff @(posedge clk200) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register doubles as the Data output, so it only moves on a beat
    // prefetch and otherwise keeps presenting the last sample.
    always_ff @(posedge clk200 or negedge rstn) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/frame_sample_tx.sv
// rtl/frame_sample_tx.sv - replays a loaded frame as Collect/Valid/Data beats
// clk200, rstn  : clock, asynchronous active-low reset
// bus (master)  : load port (LdEn/LdAdd/LdData -> LdErr) and capture stream (Collect/Valid/Data)
// Start, Abort  : begin / terminate a frame
// Gap           : idle cycles between beats, captured on an accepted Start
// Busy, Done    : frame in progress / one-cycle end-of-hold pulse
module frame_sample_tx
    import frame_tx_pkg::*;
#(
    parameter int DATA_SIZE   = DEF_DATA_SIZE,
    parameter int LENGTH      = DEF_LENGTH,
    parameter int LENGTH_SIZE = DEF_LENGTH_SIZE,
    parameter int PRE_CYC     = 2,
    parameter int POST_CYC    = 4,
    parameter int HOLD_CYC    = 160
) (
    input  logic             clk200,
    input  logic             rstn,
    frame_sample_tx_if.master bus,
    input  logic             Start,
    input  logic             Abort,
    input  logic [GAP_W-1:0] Gap,
    output logic             Busy,
    output logic             Done
);

    localparam logic [HOLD_W-1:0]      PRE_LAST  = HOLD_W'(PRE_CYC - 1);
    localparam logic [HOLD_W-1:0]      POST_LAST = HOLD_W'(POST_CYC - 1);
    localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [LENGTH_SIZE-1:0] LAST_BEAT = LENGTH_SIZE'(LENGTH - 1);

    tx_state_e              state_q, state_d;
    logic [HOLD_W-1:0]      cnt_q, cnt_d;      // cycles spent in PRE/POST/HOLD
    logic [GAP_W-1:0]       gcnt_q, gcnt_d;    // position within a beat slot, 0 = beat cycle
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [LENGTH_SIZE-1:0] beat_q, beat_d;
    logic                   collect_q, collect_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   lderr_q, lderr_d;
    logic                   wr_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        gap_d   = gap_q;
        beat_d  = beat_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = PRE;
                    cnt_d   = '0;
                    gap_d   = Gap;
                end
            end
            PRE: begin
                if (Abort) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == PRE_LAST) begin
                    state_d = SEND;
                    gcnt_d  = '0;
                    beat_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (Abort) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (gcnt_q == '0 && beat_q == LAST_BEAT) begin
                    // Leave straight from the last beat so the counter never wraps.
                    state_d = POST;
                    cnt_d   = '0;
                end else if (gcnt_q == gap_q) begin
                    gcnt_d = '0;
                    beat_d = beat_q + 1'b1;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            POST: begin
                if (Abort || cnt_q == POST_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        collect_d = (state_d == PRE) || (state_d == SEND) || (state_d == POST);
        valid_d   = (state_d == SEND) && (gcnt_d == '0);
        done_d    = (state_d == HOLD) && (cnt_d == HOLD_LAST);
        busy_d    = (state_d != IDLE) && !done_d;
        wr_en     = bus.LdEn && !busy_q;
        lderr_d   = bus.LdEn && busy_q;
    end

    always_ff @(posedge clk200 or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gcnt_q    <= '0;
            gap_q     <= '0;
            beat_q    <= '0;
            collect_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lderr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gcnt_q    <= gcnt_d;
            gap_q     <= gap_d;
            beat_q    <= beat_d;
            collect_q <= collect_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            lderr_q   <= lderr_d;
        end
    end

    // Read is issued exactly in the cycle before each beat, at that beat's address.
    frame_tx_buf #(
        .DATA_SIZE   (DATA_SIZE),
        .LENGTH      (LENGTH),
        .LENGTH_SIZE (LENGTH_SIZE)
    ) u_buf (
        .clk200    (clk200),
        .rstn      (rstn),
        .wr_en_i   (wr_en),
        .wr_addr_i (bus.LdAdd),
        .wr_data_i (bus.LdData),
        .rd_en_i   (valid_d),
        .rd_addr_i (beat_d),
        .rd_data_o (bus.Data)
    );

    assign bus.Collect = collect_q;
    assign bus.Valid   = valid_q;
    assign bus.LdErr   = lderr_q;
    assign Busy        = busy_q;
    assign Done        = done_q;

endmodule

// File: tb/tb_frame_sample_tx.sv
// tb/tb_frame_sample_tx.sv - self-checking bench for frame_sample_tx
`timescale 1ns/1ps
module tb_frame_sample_tx;
    import frame_tx_pkg::*;

    localparam int DS = 4, L = 64, LS = 6, PRE = 2, POST = 4, HOLD = 160;

    logic       clk200 = 1'b0;
    logic       rstn;
    logic       Start, Abort;
    logic [3:0] Gap;
    logic       Busy, Done;

    always #5 clk200 = ~clk200;

    frame_sample_tx_if #(.DATA_SIZE(DS), .LENGTH_SIZE(LS)) bus ();

    frame_sample_tx #(
        .DATA_SIZE(DS), .LENGTH(L), .LENGTH_SIZE(LS),
        .PRE_CYC(PRE), .POST_CYC(POST), .HOLD_CYC(HOLD)
    ) dut (
        .clk200 (clk200),
        .rstn   (rstn),
        .bus    (bus),
        .Start  (Start),
        .Abort  (Abort),
        .Gap    (Gap),
        .Busy   (Busy),
        .Done   (Done)
    );

    typedef struct {
        int gap;
        int ab;     // cycle (relative to Start) carrying Abort, -1 none
        int wr;     // cycle carrying a write of 9 to address 5, -1 none
        int beats;
        int fall;   // first cycle with Collect low again
        int done;
        int b5;     // data expected on beat 5, -1 skip
    } vec_t;

    vec_t tbl[6];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: one frame described by its start cycle, gap and hold start.
    bit         m_act;
    int         m_ts, m_gap, m_hs;
    logic [3:0] m_mem [L];
    logic [3:0] m_last;
    bit         m_lderr;

    logic       s_collect, s_valid, s_busy, s_done, s_lderr;
    logic [3:0] s_data;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic bit m_idle(int c);
        return !m_act || c >= m_hs + HOLD;
    endfunction

    function automatic bit m_collect(int c);
        return m_act && c >= m_ts + 1 && c < m_hs;
    endfunction

    function automatic bit m_busy(int c);
        return m_act && c >= m_ts + 1 && c < m_hs + HOLD - 1;
    endfunction

    function automatic bit m_done(int c);
        return m_act && c == m_hs + HOLD - 1;
    endfunction

    function automatic int m_beat(int c);
        int rel;
        if (!m_collect(c)) return -1;
        rel = c - m_ts - 1 - PRE;
        if (rel < 0 || rel % (m_gap + 1) != 0 || rel / (m_gap + 1) >= L) return -1;
        return rel / (m_gap + 1);
    endfunction

    task automatic model_reset();
        m_act   = 1'b0;
        m_last  = '0;
        m_lderr = 1'b0;
    endtask

    task automatic check_cycle();
        int k;
        k = m_beat(cyc);
        if (k >= 0) m_last = m_mem[k];
        chk("collect", 32'(s_collect), 32'(m_collect(cyc)));
        chk("valid",   32'(s_valid),   32'(k >= 0));
        chk("busy",    32'(s_busy),    32'(m_busy(cyc)));
        chk("done",    32'(s_done),    32'(m_done(cyc)));
        chk("lderr",   32'(s_lderr),   32'(m_lderr));
        chk("data",    32'(s_data),    32'(m_last));
    endtask

    task automatic model_update();
        bit b;
        if (!rstn) begin
            model_reset();
            return;
        end
        b = m_busy(cyc);
        m_lderr = bus.LdEn && b;
        if (bus.LdEn && !b) m_mem[bus.LdAdd] = bus.LdData;
        if (Start && m_idle(cyc)) begin
            m_act = 1'b1;
            m_ts  = cyc;
            m_gap = int'(Gap);
            m_hs  = cyc + 1 + PRE + (L - 1) * (m_gap + 1) + 1 + POST;
        end else if (Abort && m_collect(cyc)) begin
            m_hs = cyc + 1;
        end
    endtask

    // Inputs set before the call are the ones sampled at the end of this cycle.
    task automatic tick();
        @(negedge clk200);
        s_collect = bus.Collect;
        s_valid   = bus.Valid;
        s_busy    = Busy;
        s_done    = Done;
        s_lderr   = bus.LdErr;
        s_data    = bus.Data;
        check_cycle();
        model_update();
        @(posedge clk200);
        #1;
        cyc++;
    endtask

    task automatic load_ramp();
        for (int k = 0; k < L; k++) begin
            bus.LdEn   = 1'b1;
            bus.LdAdd  = LS'(k);
            bus.LdData = DS'(k % 16);
            tick();
        end
        bus.LdEn = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input bit poke);
        int         beats, fall, done;
        bit         prev;
        logic [3:0] d5;
        beats = 0; fall = -1; done = -1; prev = 1'b0; d5 = '0;
        Gap = 4'(v.gap);
        for (int r = 0; r < 1400; r++) begin
            Start      = (r == 0) || (r == v.done) || (poke && r > 1 && $urandom_range(0, 31) == 0);
            Abort      = (r == v.ab);
            bus.LdEn   = (r == v.wr);
            bus.LdAdd  = 6'd5;
            bus.LdData = 4'd9;
            tick();
            if (r == 1) chk("collect_rise", 32'(s_collect), 32'd1);
            if (v.wr > 0 && r == v.wr + 1) chk("lderr_pulse", 32'(s_lderr), 32'd1);
            if (s_valid) begin
                if (beats == 5) d5 = s_data;
                beats++;
            end
            if (prev && !s_collect && fall < 0) fall = r;
            prev = s_collect;
            if (s_done) begin
                done = r;
                chk("busy_at_done", 32'(s_busy), 32'd0);
                break;
            end
        end
        Start = 1'b0; Abort = 1'b0; bus.LdEn = 1'b0;
        chk("beat_count",   32'(beats), 32'(v.beats));
        chk("collect_fall", 32'(fall),  32'(v.fall));
        chk("done_cycle",   32'(done),  32'(v.done));
        if (v.b5 >= 0) chk("beat5_data", 32'(d5), 32'(v.b5));
    endtask

    task automatic rand_frame();
        int  g, ab;
        bit  got;
        for (int i = 0; i < 8; i++) begin
            bus.LdEn   = 1'b1;
            bus.LdAdd  = LS'($urandom_range(0, L - 1));
            bus.LdData = DS'($urandom_range(0, 15));
            tick();
        end
        g   = $urandom_range(0, 15);
        ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 300) : -1;
        got = 1'b0;
        Gap = 4'(g);
        for (int r = 0; r < 1500 && !got; r++) begin
            Start      = (r == 0) || ($urandom_range(0, 63) == 0);
            Abort      = (r == ab);
            bus.LdEn   = ($urandom_range(0, 5) == 0);
            bus.LdAdd  = LS'($urandom_range(0, L - 1));
            bus.LdData = DS'($urandom_range(0, 15));
            tick();
            got = s_done;
        end
        Start = 1'b0; Abort = 1'b0; bus.LdEn = 1'b0;
        chk("rand_frame_done", 32'(got), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        tbl[0] = '{gap: 0,  ab: -1, wr: 10, beats: 64, fall: 71,   done: 230,  b5: 5};
        tbl[1] = '{gap: 3,  ab: -1, wr: 0,  beats: 64, fall: 260,  done: 419,  b5: 9};
        tbl[2] = '{gap: 0,  ab: 22, wr: -1, beats: 20, fall: 23,   done: 182,  b5: 9};
        tbl[3] = '{gap: 2,  ab: 32, wr: -1, beats: 10, fall: 33,   done: 192,  b5: 9};
        tbl[4] = '{gap: 0,  ab: 1,  wr: -1, beats: 0,  fall: 2,    done: 161,  b5: -1};
        tbl[5] = '{gap: 15, ab: -1, wr: -1, beats: 64, fall: 1016, done: 1175, b5: 9};

        rstn = 1'b0; Start = 1'b0; Abort = 1'b0; Gap = '0;
        bus.LdEn = 1'b0; bus.LdAdd = '0; bus.LdData = '0;
        model_reset();
        @(posedge clk200); #1;
        tick();
        tick();
        rstn = 1'b1;
        tick();

        load_ramp();
        for (int i = 0; i < 6; i++) run_frame(tbl[i], 1'b1);

        // Reset in the middle of SEND.
        Gap = 4'd0;
        for (int r = 0; r <= 30; r++) begin
            Start = (r == 0);
            tick();
        end
        Start = 1'b0;
        rstn  = 1'b0;
        model_reset();
        #1;
        chk("rst_collect", 32'(bus.Collect), 32'd0);
        chk("rst_valid",   32'(bus.Valid),   32'd0);
        chk("rst_busy",    32'(Busy),        32'd0);
        tick();
        tick();
        tick();
        rstn = 1'b1;
        load_ramp();
        rv = '{gap: 0, ab: -1, wr: -1, beats: 64, fall: 71, done: 230, b5: 5};
        run_frame(rv, 1'b0);

        for (int i = 0; i < 6; i++) rand_frame();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
